// File: rtl/as_gpio_mon_pkg.sv
// Shared types for the GPIO write monitor: FSM states, failure codes and the
// expectation-queue entry. Default widths match the RV64I core's GPIO port.
package as_pack;

  localparam int nr_gpios        = 16;
  localparam int gpio_addr_width = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_DATA    = 2'd1,
    FAIL_ADDR    = 2'd2,
    FAIL_TIMEOUT = 2'd3
  } mon_fail_t;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [nr_gpios-1:0]        data;
    logic [nr_gpios-1:0]        mask;
  } mon_exp_t;

endpackage

// File: rtl/as_gpio_mon_fifo.sv
// Synchronous FIFO with show-ahead head, used as the expectation queue.
// Push is dropped when full and pop when empty; flush clears the occupancy.
module as_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_cnt == FULL_CNT);
  assign empty_o = (r_cnt == '0);
  assign count_o = r_cnt;
  assign head_o  = r_mem[r_rd];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i && !flush_i) r_mem[r_wr] <= din_i;
  end

endmodule

// File: rtl/as_gpio_mon.sv
// GPIO write monitor: checks chip-select strobes against an ordered queue of
// (addr, data, mask) expectations. Optional watchdog: AS_GPIO_MON_TIMEOUT_EN.
module as_gpio_mon
  import as_pack::*;
#(
  parameter int GPIO_W      = nr_gpios,
  parameter int ADDR_W      = gpio_addr_width,
  parameter int EXP_DEPTH   = 16,
  parameter int WIN_BASE    = 4,
  parameter int NR_CH       = 4,
  parameter int STRICT      = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cs_i,
  input  logic [ADDR_W-1:0]              gpioAddr_i,
  input  logic [GPIO_W-1:0]              gpio_i,
  input  logic                           ld_valid_i,
  output logic                           ld_ready_o,
  input  logic [ADDR_W-1:0]              ld_addr_i,
  input  logic [GPIO_W-1:0]              ld_data_i,
  input  logic [GPIO_W-1:0]              ld_mask_i,
  input  logic                           arm_i,
  input  logic                           clr_i,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           fail_o,
  output logic [1:0]                     fail_code_o,
  output logic [ADDR_W-1:0]              fail_addr_o,
  output logic [GPIO_W-1:0]              fail_data_o,
  output logic [$clog2(EXP_DEPTH+1)-1:0] match_cnt_o,
  output logic [7:0]                     stray_cnt_o,
  output mon_state_t                     dbg_state_o
);

  localparam int CW = $clog2(EXP_DEPTH+1);
  localparam int QW = $clog2(EXP_DEPTH);
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(WIN_BASE);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(WIN_BASE + NR_CH);

  mon_state_t        r_state;
  logic              r_done, r_pass, r_fail;
  mon_fail_t         r_code;
  logic [ADDR_W-1:0] r_faddr;
  logic [GPIO_W-1:0] r_fdata;
  logic [CW-1:0]     r_match;
  logic [7:0]        r_stray;

  mon_exp_t          w_ld_entry;
  mon_exp_t          w_head;
  logic              w_full, w_empty;
  logic [QW:0]       w_count;
  logic              w_push, w_pop, w_in_win, w_armed_act;
  logic              w_fail_now, w_match_now, w_stray_now, w_last;
  mon_fail_t         w_code;
  logic              w_wdog_hit;

  assign w_ld_entry = '{addr: ld_addr_i, data: ld_data_i, mask: ld_mask_i};
  assign ld_ready_o = ((r_state == ST_IDLE) || (r_state == ST_ARMED)) && !w_full;
  assign w_push     = ld_valid_i && ld_ready_o;
  assign w_in_win   = ({1'b0, gpioAddr_i} >= WIN_LO) && ({1'b0, gpioAddr_i} < WIN_HI);
  // arm_i outranks strobes, so a strobe coinciding with arm is not processed.
  assign w_armed_act = (r_state == ST_ARMED) && !arm_i && !clr_i;
  assign w_pop      = w_armed_act && cs_i && w_in_win;
  assign w_last     = (w_count == (QW+1)'(1)) && !w_push;

  as_sync_fifo #(
    .W     ($bits(mon_exp_t)),
    .DEPTH (EXP_DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clr_i),
    .push_i  (w_push),
    .din_i   (w_ld_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

`ifdef AS_GPIO_MON_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYC - 1);
  logic [WW-1:0] r_wdog;

  // Saturates at the limit so a timeout masked by a stray strobe still fires.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || r_state != ST_ARMED || arm_i || (cs_i && w_in_win))
      r_wdog <= '0;
    else if (r_wdog != WD_LIM)
      r_wdog <= r_wdog + WW'(1);
  end
  assign w_wdog_hit = (r_state == ST_ARMED) && (r_wdog == WD_LIM);
`else
  assign w_wdog_hit = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    w_fail_now  = 1'b0;
    w_match_now = 1'b0;
    w_stray_now = 1'b0;
    w_code      = FAIL_NONE;
    if (w_armed_act && cs_i) begin
      if (w_in_win) begin
        if (w_empty || gpioAddr_i != w_head.addr) begin
          w_fail_now = 1'b1;
          w_code     = FAIL_ADDR;
        end else if (((gpio_i ^ w_head.data) & w_head.mask) != '0) begin
          w_fail_now = 1'b1;
          w_code     = FAIL_DATA;
        end else begin
          w_match_now = 1'b1;
        end
      end else begin
        w_stray_now = 1'b1;
        if (STRICT != 0) begin
          w_fail_now = 1'b1;
          w_code     = FAIL_ADDR;
        end
      end
    end else if (w_armed_act && w_wdog_hit) begin
      w_fail_now = 1'b1;
      w_code     = FAIL_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= FAIL_NONE;
      r_faddr <= '0;
      r_fdata <= '0;
      r_match <= '0;
      r_stray <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm_i) begin
            if (w_empty) begin
              r_state <= ST_PASS;
              r_pass  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (w_stray_now && r_stray != 8'hFF) r_stray <= r_stray + 8'd1;
          if (w_fail_now) begin
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
            r_done  <= 1'b1;
            r_code  <= w_code;
            r_faddr <= (w_code == FAIL_TIMEOUT) ? '0 : gpioAddr_i;
            r_fdata <= (w_code == FAIL_TIMEOUT) ? '0 : gpio_i;
          end else if (w_match_now) begin
            r_match <= r_match + CW'(1);
            if (w_last) begin
              r_state <= ST_PASS;
              r_pass  <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign fail_code_o = r_code;
  assign fail_addr_o = r_faddr;
  assign fail_data_o = r_fdata;
  assign match_cnt_o = r_match;
  assign stray_cnt_o = r_stray;
  assign dbg_state_o = r_state;

endmodule
